// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle RV32I control FSM.
// Opcodes, state encodings, pc_sel / wb_sel codes and opcode classifier.
package multicycle_ctrl_pkg;

    localparam int OPWIDTH = 7;

    // RV32I major opcodes
    localparam logic [OPWIDTH-1:0] RTYPE  = 7'b0110011;
    localparam logic [OPWIDTH-1:0] IARITH = 7'b0010011;
    localparam logic [OPWIDTH-1:0] ILOAD  = 7'b0000011;
    localparam logic [OPWIDTH-1:0] STYPE  = 7'b0100011;
    localparam logic [OPWIDTH-1:0] BTYPE  = 7'b1100011;
    localparam logic [OPWIDTH-1:0] JAL    = 7'b1101111;
    localparam logic [OPWIDTH-1:0] JALR   = 7'b1100111;
    localparam logic [OPWIDTH-1:0] LUI    = 7'b0110111;
    localparam logic [OPWIDTH-1:0] AUIPC  = 7'b0010111;

    // FSM state encodings
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd7;

    // pc_sel codes
    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_REL  = 2'd1;
    localparam logic [1:0] PC_JALR = 2'd2;

    // wb_sel codes
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    typedef enum logic [3:0] {
        OP_BAD,
        OP_R,
        OP_I,
        OP_LD,
        OP_ST,
        OP_BR,
        OP_JAL,
        OP_JALR,
        OP_LUI,
        OP_AUIPC
    } op_class_e;

    function automatic op_class_e op_class(
        input logic [OPWIDTH-1:0] op
    );
        op_class_e c;
        unique case (op)
            RTYPE:   c = OP_R;
            IARITH:  c = OP_I;
            ILOAD:   c = OP_LD;
            STYPE:   c = OP_ST;
            BTYPE:   c = OP_BR;
            JAL:     c = OP_JAL;
            JALR:    c = OP_JALR;
            LUI:     c = OP_LUI;
            AUIPC:   c = OP_AUIPC;
            default: c = OP_BAD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_handshake_timer.sv
// Wait counter for a memory handshake with saturating timeout compare.
// Ports: clk, rst (async active-low), clr, run, ready in; expired out.
module handshake_timer #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic ready,
    output logic expired
);

    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Counter parks at LIMIT so a long stall can never wrap to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run && !ready && cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, write-back.
// In: clk, rst, en, opcode, branch_taken, imem/dmem ready. Out: strobes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [OPWIDTH-1:0] opcode,
    input  logic               branch_taken,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_we,
    output logic               dec_en,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic               alu_src_b,
    output logic [1:0]         wb_sel,
    output logic               pc_we,
    output logic [1:0]         pc_sel,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               retire,
    output logic               fault,
    output logic [2:0]         state
);

    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       fault_q;
    logic       fault_d;

    op_class_e  cls;
    logic       wait_run;
    logic       wait_ready;
    logic       timer_clr;
    logic       expired;

    assign cls = op_class(opcode);

    assign wait_run   = (state_q == FETCH) || (state_q == MEM);
    assign wait_ready = (state_q == MEM) ? dmem_ready : imem_ready;

    // Restart the count only on entry, so a held request keeps counting.
    assign timer_clr = ((state_d == FETCH) || (state_d == MEM))
                     && (state_d != state_q);

    handshake_timer #(
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .run     (wait_run),
        .ready   (wait_ready),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dec_en    = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_SEQ;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                imem_req = 1'b1;
                // Ready beats an expired counter in the same cycle.
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (expired) begin
                    state_d = HALT;
                end
            end

            DECODE: begin
                dec_en = 1'b1;
                if (cls == OP_BAD) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end

            EXEC: begin
                case (cls)
                    OP_R: begin
                        state_d = WB;
                    end
                    OP_I, OP_LUI, OP_JAL, OP_JALR: begin
                        alu_src_b = 1'b1;
                        state_d   = WB;
                    end
                    OP_AUIPC: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src_b = 1'b1;
                        state_d   = MEM;
                    end
                    OP_BR: begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken ? PC_REL : PC_SEQ;
                        retire = 1'b1;
                    end
                    default: begin
                        state_d = HALT;
                    end
                endcase
            end

            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == OP_ST);
                if (dmem_ready) begin
                    if (cls == OP_ST) begin
                        pc_we  = 1'b1;
                        pc_sel = PC_SEQ;
                        retire = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (expired) begin
                    state_d = HALT;
                end
            end

            WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                case (cls)
                    OP_LD: begin
                        wb_sel = WB_LOAD;
                    end
                    OP_LUI: begin
                        wb_sel = WB_IMM;
                    end
                    OP_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_REL;
                    end
                    OP_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_JALR;
                    end
                    default: begin
                        wb_sel = WB_ALU;
                    end
                endcase
            end

            HALT: begin
                state_d = HALT;
            end

            default: begin
                state_d = HALT;
            end
        endcase

        // en is only honoured at instruction boundaries.
        if (retire) begin
            state_d = en ? FETCH : IDLE;
        end
    end

    assign fault_d = fault_q || (state_d == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (TIMEOUT=4).
// Per-cycle expected outputs are queued by the driver, checked at negedge.
module tb_multicycle_ctrl;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DEC   = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_MEM   = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd7;

    localparam logic [10:0] F_IREQ = 11'd1;
    localparam logic [10:0] F_IRWE = 11'd2;
    localparam logic [10:0] F_DEC  = 11'd4;
    localparam logic [10:0] F_RW   = 11'd8;
    localparam logic [10:0] F_SA   = 11'd16;
    localparam logic [10:0] F_SB   = 11'd32;
    localparam logic [10:0] F_PCWE = 11'd64;
    localparam logic [10:0] F_DREQ = 11'd128;
    localparam logic [10:0] F_DWE  = 11'd256;
    localparam logic [10:0] F_RET  = 11'd512;
    localparam logic [10:0] F_FLT  = 11'd1024;

    localparam logic [6:0] OP_ADD  = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_we;
        logic       dec_en;
        logic       reg_write;
        logic       src_a;
        logic       src_b;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       dmem_req;
        logic       dmem_we;
        logic       retire;
        logic       fault;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] opc;
    logic       bt;
    logic       imem_ready;
    logic       dmem_ready;
    logic       imem_req;
    logic       ir_we;
    logic       dec_en;
    logic       reg_write;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [1:0] wb_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       dmem_req;
    logic       dmem_we;
    logic       retire;
    logic       fault;
    logic [2:0] state;

    int    n_cmp;
    int    n_err;
    string scn;
    obs_t  sb[$];
    string tq[$];

    multicycle_ctrl #(
        .TIMEOUT (4),
        .TW      (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .opcode       (opc),
        .branch_taken (bt),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .dec_en       (dec_en),
        .reg_write    (reg_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .retire       (retire),
        .fault        (fault),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t obs_now();
        obs_t o;
        o.st        = state;
        o.imem_req  = imem_req;
        o.ir_we     = ir_we;
        o.dec_en    = dec_en;
        o.reg_write = reg_write;
        o.src_a     = alu_src_a;
        o.src_b     = alu_src_b;
        o.wb_sel    = wb_sel;
        o.pc_we     = pc_we;
        o.pc_sel    = pc_sel;
        o.dmem_req  = dmem_req;
        o.dmem_we   = dmem_we;
        o.retire    = retire;
        o.fault     = fault;
        return o;
    endfunction

    function automatic obs_t mk(
        input logic [2:0]  st,
        input logic [10:0] f,
        input logic [1:0]  wb,
        input logic [1:0]  ps
    );
        obs_t o;
        o.st        = st;
        o.imem_req  = f[0];
        o.ir_we     = f[1];
        o.dec_en    = f[2];
        o.reg_write = f[3];
        o.src_a     = f[4];
        o.src_b     = f[5];
        o.pc_we     = f[6];
        o.dmem_req  = f[7];
        o.dmem_we   = f[8];
        o.retire    = f[9];
        o.fault     = f[10];
        o.wb_sel    = wb;
        o.pc_sel    = ps;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    always @(negedge clk) begin : mon
        obs_t  e;
        obs_t  g;
        string t;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tq.pop_front();
            g = obs_now();
            chk({t, "/state"}, 32'(g.st), 32'(e.st));
            chk({t, "/outs"}, 32'(g), 32'(e));
        end
    end

    task automatic cyc(
        input logic        e,
        input logic        b,
        input logic        ir,
        input logic        dr,
        input logic [2:0]  st,
        input logic [10:0] f,
        input logic [1:0]  wb = 2'd0,
        input logic [1:0]  ps = 2'd0
    );
        en         = e;
        bt         = b;
        imem_ready = ir;
        dmem_ready = dr;
        sb.push_back(mk(st, f, wb, ps));
        tq.push_back($sformatf("%s@%0t", scn, $time));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic e);
        cyc(e, rb(), rb(), rb(), S_IDLE, 11'd0);
    endtask

    task automatic instr(
        input string      nm,
        input logic [6:0] o,
        input int         iw,
        input int         dw,
        input logic       b,
        input logic       enr
    );
        logic [10:0] ef;
        logic [1:0]  wb;
        logic [1:0]  ps;
        logic        mem;
        logic        str;
        logic        br;
        scn = nm;
        opc = o;
        ef  = F_SB;
        wb  = 2'd0;
        ps  = 2'd0;
        mem = 1'b0;
        str = 1'b0;
        br  = 1'b0;
        case (o)
            OP_ADD:  ef = 11'd0;
            OP_AUI:  ef = F_SA | F_SB;
            OP_LUI:  wb = 2'd3;
            OP_JAL:  begin wb = 2'd2; ps = 2'd1; end
            OP_JALR: begin wb = 2'd2; ps = 2'd2; end
            OP_LW:   begin mem = 1'b1; wb = 2'd1; end
            OP_SW:   begin mem = 1'b1; str = 1'b1; end
            OP_BEQ:  br = 1'b1;
            default: ;
        endcase
        for (int i = 0; i < iw; i++) begin
            cyc(rb(), rb(), 1'b0, rb(), S_FETCH, F_IREQ);
        end
        cyc(rb(), rb(), 1'b1, rb(), S_FETCH, F_IREQ | F_IRWE);
        cyc(rb(), rb(), rb(), rb(), S_DEC, F_DEC);
        if (br) begin
            cyc(enr, b, rb(), rb(), S_EXEC, F_PCWE | F_RET,
                2'd0, b ? 2'd1 : 2'd0);
            return;
        end
        cyc(rb(), rb(), rb(), rb(), S_EXEC, ef);
        if (mem) begin
            for (int i = 0; i < dw; i++) begin
                cyc(rb(), rb(), rb(), 1'b0, S_MEM,
                    F_DREQ | (str ? F_DWE : 11'd0));
            end
            if (str) begin
                cyc(enr, rb(), rb(), 1'b1, S_MEM,
                    F_DREQ | F_DWE | F_PCWE | F_RET);
                return;
            end
            cyc(rb(), rb(), rb(), 1'b1, S_MEM, F_DREQ);
        end
        cyc(enr, rb(), rb(), rb(), S_WB, F_RW | F_PCWE | F_RET, wb, ps);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b0;
        #1;
        chk({nm, "/rst_state"}, 32'(state), 32'(S_IDLE));
        chk({nm, "/rst_outs"}, 32'(obs_now()), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        scn        = "init";
        rst        = 1'b0;
        en         = 1'b0;
        opc        = 7'd0;
        bt         = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        do_reset("init");

        scn = "idle";
        idle(1'b0);
        idle(1'b1);
        instr("add",      OP_ADD,  0, 0, 1'b0, 1'b1);
        instr("lw_wait3", OP_LW,   0, 3, 1'b0, 1'b1);
        instr("beq_t",    OP_BEQ,  0, 0, 1'b1, 1'b1);
        instr("beq_nt",   OP_BEQ,  0, 0, 1'b0, 1'b1);
        instr("jalr",     OP_JALR, 0, 0, 1'b0, 1'b1);
        instr("jal",      OP_JAL,  0, 0, 1'b0, 1'b1);
        instr("lui",      OP_LUI,  0, 0, 1'b0, 1'b1);
        instr("auipc",    OP_AUI,  0, 0, 1'b0, 1'b1);
        instr("addi",     OP_ADDI, 0, 0, 1'b0, 1'b1);
        instr("sw",       OP_SW,   0, 0, 1'b0, 1'b1);
        instr("sw_wait2", OP_SW,   0, 2, 1'b0, 1'b1);
        instr("add_if2",  OP_ADD,  2, 0, 1'b0, 1'b1);
        instr("add_if4",  OP_ADD,  4, 0, 1'b0, 1'b1);
        instr("lw_edge",  OP_LW,   1, 4, 1'b0, 1'b1);
        instr("lw_enlo",  OP_LW,   0, 0, 1'b0, 1'b0);
        scn = "en_low";
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        instr("sw_enlo",  OP_SW,   0, 0, 1'b0, 1'b0);
        scn = "en_back";
        idle(1'b1);
        instr("add_last", OP_ADD,  0, 0, 1'b0, 1'b1);

        scn = "rst_mem";
        opc = OP_LW;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_FETCH, F_IREQ | F_IRWE);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_DEC, F_DEC);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_EXEC, F_SB);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_MEM, F_DREQ);
        chk("rst_mem/req_before", 32'(dmem_req), 32'(1));
        en = 1'b0;
        do_reset("rst_mem");

        scn = "bad_op";
        opc = 7'b1111111;
        idle(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, S_FETCH, F_IREQ | F_IRWE);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, S_DEC, F_DEC);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, S_HALT, F_FLT);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, S_HALT, F_FLT);
        en = 1'b0;
        do_reset("bad_op");

        scn = "to_fetch";
        opc = OP_LW;
        idle(1'b1);
        repeat (5) cyc(rb(), rb(), 1'b0, rb(), S_FETCH, F_IREQ);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, S_HALT, F_FLT);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, S_HALT, F_FLT);
        en = 1'b0;
        do_reset("to_fetch");

        scn = "to_mem";
        opc = OP_LW;
        idle(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_FETCH, F_IREQ | F_IRWE);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_DEC, F_DEC);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, S_EXEC, F_SB);
        repeat (5) cyc(rb(), rb(), rb(), 1'b0, S_MEM, F_DREQ);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, S_HALT, F_FLT);
        en = 1'b0;
        do_reset("to_mem");

        chk("sb_drained", 32'(sb.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
